// File: rtl/pattern_game_engine_if.sv
// Switch/LED/scoreboard bundle of the pattern game engine.
// The engine connects through master; the switch/display side connects through slave.
interface pattern_game_engine_if #(
    parameter int NUM_CHANNELS = 4
) ();
    logic [NUM_CHANNELS-1:0] i_switch;
    logic [NUM_CHANNELS-1:0] o_led;
    logic [3:0]              o_score;
    logic                    o_win;
    logic                    o_lose;

    modport master (
        input  i_switch,
        output o_led,
        output o_score,
        output o_win,
        output o_lose
    );

    modport slave (
        output i_switch,
        input  o_led,
        input  o_score,
        input  o_win,
        input  o_lose
    );
endinterface

// File: rtl/pattern_game_engine.sv
// N-channel Simon-style game engine: shows a growing LFSR-derived sequence and checks switch releases.
// Defining PATTERN_GAME_TIMEOUT_EN adds a player inactivity timeout in WAIT_PLAYER.
module pattern_game_engine #(
    parameter int NUM_CHANNELS = 4,
    parameter int GAME_LIMIT   = 7,
    parameter int CLKS_PER_SEC = 25000000,
    parameter int TIMEOUT_SEC  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pattern_game_engine_if.master bus
);
    localparam int W      = $clog2(NUM_CHANNELS);
    localparam int T_HALF = (CLKS_PER_SEC / 4 > 0) ? CLKS_PER_SEC / 4 : 1;
    localparam int TW     = $clog2(T_HALF) + 1;
    localparam int PW     = GAME_LIMIT * W;
    localparam logic [TW-1:0] T_RELOAD = TW'(T_HALF - 1);
    localparam logic [3:0]    LIMIT    = 4'(GAME_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PATTERN_OFF,
        PATTERN_SHOW,
        WAIT_PLAYER,
        INCR_SCORE,
        WINNER,
        LOSER
    } state_t;

    state_t                  state, state_next;
    logic [TW-1:0]           timer;
    logic [31:0]             lfsr;
    logic [NUM_CHANNELS-1:0] prev;
    logic [NUM_CHANNELS-1:0] released;
    logic [NUM_CHANNELS-1:0] cur_mask;
    logic [NUM_CHANNELS-1:0] next_mask;
    logic [3:0]              score, score_next;
    logic [3:0]              idx, idx_next;
    logic [PW-1:0]           pattern;
    logic [W-1:0]            cur_elem, next_elem;
    logic                    load;
    logic                    timer_done;
    logic                    combo;
    logic                    single_release;
    logic                    hit;
    logic                    expired;
    logic [NUM_CHANNELS-1:0] led_d;
    logic [3:0]              score_d;
    logic                    win_d;
    logic                    lose_d;

    assign released       = prev & ~bus.i_switch;
    assign single_release = (released != '0) && ((released & (released - 1'b1)) == '0);
    assign combo          = bus.i_switch[0] & bus.i_switch[1];
    assign timer_done     = (timer == '0);
    assign cur_elem       = pattern[int'(idx) * W +: W];
    assign next_elem      = pattern[int'(idx_next) * W +: W];
    assign hit            = single_release && (released == cur_mask);

    always_comb begin
        cur_mask            = '0;
        cur_mask[cur_elem]  = 1'b1;
        next_mask           = '0;
        next_mask[next_elem] = 1'b1;
    end

`ifdef PATTERN_GAME_TIMEOUT_EN
    localparam int TO_CLKS = CLKS_PER_SEC * TIMEOUT_SEC;
    localparam int TOW     = $clog2(TO_CLKS) + 1;

    logic [TOW-1:0] idle_cnt;

    assign expired = (idle_cnt == TOW'(TO_CLKS - 1));

    // Counts consecutive WAIT_PLAYER cycles without a valid release; zero on entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_cnt <= '0;
        end else if (state == WAIT_PLAYER && state_next == WAIT_PLAYER && !hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        score_next = score;
        idx_next   = idx;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (combo) begin
                    state_next = START;
                    score_next = '0;
                end
            end
            START: begin
                score_next = '0;
                if (bus.i_switch == '0) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = PATTERN_OFF;
                end
            end
            PATTERN_OFF: begin
                if (timer_done) state_next = PATTERN_SHOW;
            end
            PATTERN_SHOW: begin
                if (timer_done) begin
                    if (idx == score) begin
                        idx_next   = '0;
                        state_next = WAIT_PLAYER;
                    end else begin
                        idx_next   = idx + 4'd1;
                        state_next = PATTERN_OFF;
                    end
                end
            end
            WAIT_PLAYER: begin
                if (released != '0) begin
                    if (!hit) begin
                        state_next = LOSER;
                    end else if (idx == score) begin
                        state_next = INCR_SCORE;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end else if (expired) begin
                    state_next = LOSER;
                end
            end
            INCR_SCORE: begin
                score_next = score + 4'd1;
                idx_next   = '0;
                state_next = (score_next == LIMIT) ? WINNER : PATTERN_OFF;
            end
            WINNER, LOSER: begin
                if (combo) begin
                    state_next = START;
                    score_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state register.
        led_d   = '0;
        score_d = score_next;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        case (state_next)
            PATTERN_SHOW: led_d = next_mask;
            WAIT_PLAYER:  led_d = bus.i_switch;
            WINNER: begin
                led_d   = '1;
                score_d = 4'hA;
                win_d   = 1'b1;
            end
            LOSER: begin
                score_d = 4'hF;
                lose_d  = 1'b1;
            end
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            timer       <= '0;
            lfsr        <= 32'h1;
            prev        <= '0;
            score       <= '0;
            idx         <= '0;
            pattern     <= '0;
            bus.o_led   <= '0;
            bus.o_score <= '0;
            bus.o_win   <= 1'b0;
            bus.o_lose  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= T_RELOAD;
            end else if (!timer_done) begin
                timer <= timer - 1'b1;
            end
            lfsr  <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            prev  <= bus.i_switch;
            score <= score_next;
            idx   <= idx_next;
            if (load) pattern <= lfsr[PW-1:0];
            bus.o_led   <= led_d;
            bus.o_score <= score_d;
            bus.o_win   <= win_d;
            bus.o_lose  <= lose_d;
        end
    end
endmodule

// File: tb/tb_pattern_game_engine.sv
// Randomised bench for pattern_game_engine against a script/queue based game model.
// Honours PATTERN_GAME_TIMEOUT_EN in the model and in the idle-player checks.
module tb_pattern_game_engine;
    localparam int NC      = 4;
    localparam int GL      = 2;
    localparam int CPS     = 8;
    localparam int TOS     = 1;
    localparam int TH      = CPS / 4;
    localparam int TO_CLKS = CPS * TOS;

    localparam int MD_IDLE  = 0;
    localparam int MD_ARMED = 1;
    localparam int MD_SHOW  = 2;
    localparam int MD_WAIT  = 3;
    localparam int MD_BONUS = 4;
    localparam int MD_WON   = 5;
    localparam int MD_LOST  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = '0;

    pattern_game_engine_if #(.NUM_CHANNELS(NC)) bus ();
    assign bus.i_switch = sw;

    pattern_game_engine #(
        .NUM_CHANNELS(NC),
        .GAME_LIMIT(GL),
        .CLKS_PER_SEC(CPS),
        .TIMEOUT_SEC(TOS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the displayed sequence is a queue of LED values, the player's duty a queue of channels.
    int         m_mode;
    int         m_score;
    int         m_idle;
    logic [1:0] m_pat[GL];
    logic [3:0] m_prev;
    logic [3:0] m_cur;
    logic [31:0] m_lfsr;
    logic [3:0] script[$];
    int         expq[$];
    logic [3:0] e_led;
    logic [3:0] e_score;
    logic       e_win;
    logic       e_lose;

    function automatic logic [3:0] oh(input int k);
        logic [3:0] r;
        r = 4'b0001 << k;
        return r;
    endfunction

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_score = 0;
        m_idle  = 0;
        m_prev  = '0;
        m_cur   = '0;
        m_lfsr  = 32'h1;
        script.delete();
        expq.delete();
        e_led   = '0;
        e_score = '0;
        e_win   = 1'b0;
        e_lose  = 1'b0;
    endtask

    task automatic build_script();
        script.delete();
        for (int i = 0; i <= m_score; i++) begin
            repeat (TH) script.push_back(4'h0);
            repeat (TH) script.push_back(oh(int'(m_pat[i])));
        end
    endtask

    task automatic model_step();
        logic [3:0]  s;
        logic [3:0]  rel;
        logic [31:0] t;
        s   = sw;
        rel = m_prev & ~s;
        case (m_mode)
            MD_IDLE: if (s[0] && s[1]) begin m_mode = MD_ARMED; m_score = 0; end
            MD_ARMED: begin
                m_score = 0;
                if (s == 4'h0) begin
                    for (int i = 0; i < GL; i++) begin
                        t = m_lfsr >> (2 * i);
                        m_pat[i] = t[1:0];
                    end
                    build_script();
                    m_cur  = script.pop_front();
                    m_mode = MD_SHOW;
                end
            end
            MD_SHOW: begin
                if (script.size() > 0) begin
                    m_cur = script.pop_front();
                end else begin
                    m_mode = MD_WAIT;
                    m_idle = 0;
                    expq.delete();
                    for (int i = 0; i <= m_score; i++) expq.push_back(int'(m_pat[i]));
                end
            end
            MD_WAIT: begin
                if (rel != 4'h0) begin
                    if ($countones(rel) == 1 && rel == oh(expq[0])) begin
                        void'(expq.pop_front());
                        m_idle = 0;
                        if (expq.size() == 0) m_mode = MD_BONUS;
                    end else begin
                        m_mode = MD_LOST;
                    end
                end
`ifdef PATTERN_GAME_TIMEOUT_EN
                else begin
                    m_idle++;
                    if (m_idle == TO_CLKS) m_mode = MD_LOST;
                end
`endif
            end
            MD_BONUS: begin
                m_score++;
                if (m_score == GL) begin
                    m_mode = MD_WON;
                end else begin
                    build_script();
                    m_cur  = script.pop_front();
                    m_mode = MD_SHOW;
                end
            end
            default: if (s[0] && s[1]) begin m_mode = MD_ARMED; m_score = 0; end
        endcase
        m_prev = s;
        m_lfsr = {m_lfsr[30:0], ^(m_lfsr & 32'h8020_0003)};

        e_led   = '0;
        e_score = 4'(m_score);
        e_win   = 1'b0;
        e_lose  = 1'b0;
        case (m_mode)
            MD_SHOW: e_led = m_cur;
            MD_WAIT: e_led = s;
            MD_WON:  begin e_led = 4'hF; e_score = 4'hA; e_win = 1'b1; end
            MD_LOST: begin e_score = 4'hF; e_lose = 1'b1; end
            default: e_led = '0;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst) model_step();
    end

    initial forever begin
        @(negedge clk);
        n_cmp++;
        if (bus.o_led !== e_led || bus.o_score !== e_score ||
            bus.o_win !== e_win || bus.o_lose !== e_lose) begin
            n_bad++;
            $display("FAIL outputs t=%0t: got led=%h score=%h win=%b lose=%b, expected led=%h score=%h win=%b lose=%b",
                     $time, bus.o_led, bus.o_score, bus.o_win, bus.o_lose, e_led, e_score, e_win, e_lose);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int mode, input int budget);
        int n;
        n = 0;
        while (m_mode != mode && n < budget) begin
            tick();
            n++;
        end
        if (m_mode != mode) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_for: model mode %0d, required %0d within %0d cycles", m_mode, mode, budget);
        end
    endtask

    task automatic start_combo();
        sw = 4'b0011;
        tick();
        tick();
        sw = 4'b0000;
        tick();
    endtask

    task automatic press_release(input int ch, input int hold);
        sw = oh(ch);
        repeat (hold) tick();
        sw = 4'b0000;
        tick();
    endtask

    task automatic play_game(input int pct);
        int early;
        int ch;
        int a;
        int b;
        start_combo();
        for (int r = 0; r < GL; r++) begin
            early = int'($urandom_range(0, 1));
            if (early != 0) sw = oh(int'(m_pat[0]));
            wait_for(MD_WAIT, 100);
            for (int e = 0; e <= r; e++) begin
                if (e == 0 && early != 0) begin
                    repeat ($urandom_range(0, 2)) tick();
                    sw = 4'b0000;
                    tick();
                end else if (int'($urandom_range(0, 99)) < pct) begin
                    if ($urandom_range(0, 1) != 0) begin
                        ch = (int'(m_pat[e]) + 1 + int'($urandom_range(0, 2))) % 4;
                        press_release(ch, int'($urandom_range(1, 3)));
                    end else begin
                        a  = int'($urandom_range(0, 3));
                        b  = (a + 1 + int'($urandom_range(0, 2))) % 4;
                        sw = oh(a) | oh(b);
                        repeat ($urandom_range(1, 2)) tick();
                        sw = 4'b0000;
                        tick();
                    end
                    wait_for(MD_LOST, 4);
                    return;
                end else begin
                    press_release(int'(m_pat[e]), int'($urandom_range(1, 3)));
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            if (r == GL - 1) wait_for(MD_WON, 10);
            else             wait_for(MD_SHOW, 10);
        end
    endtask

    initial begin
        logic [3:0] led_s[8];
        logic [3:0] last;
        int         n_on;
        int         n_pulse;
        int         w;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_led", int'(bus.o_led), 0);
        check("reset_score", int'(bus.o_score), 0);
        check("reset_win", int'(bus.o_win), 0);
        check("reset_lose", int'(bus.o_lose), 0);
        #2 rst = 1'b0;
        tick();

        // Happy path, with the round-1 display shape pinned by hand.
        start_combo();
        wait_for(MD_WAIT, 100);
        press_release(int'(m_pat[0]), 1);
        tick();
        check("score_after_round0", int'(bus.o_score), 1);
        n_on    = 0;
        n_pulse = 0;
        last    = '0;
        for (int j = 0; j < 8; j++) begin
            led_s[j] = bus.o_led;
            if (led_s[j] != 4'h0) n_on++;
            if (led_s[j] != 4'h0 && last == 4'h0) n_pulse++;
            last = led_s[j];
            tick();
        end
        check("r1_on_cycles", n_on, 4);
        check("r1_pulses", n_pulse, 2);
        check("r1_off_gaps", int'(led_s[0] | led_s[1] | led_s[4] | led_s[5]), 0);
        check("r1_onehot_pairs", int'($onehot(led_s[2]) && led_s[2] == led_s[3] &&
                                      $onehot(led_s[6]) && led_s[6] == led_s[7]), 1);
        wait_for(MD_WAIT, 10);
        press_release(int'(m_pat[0]), 2);
        press_release(int'(m_pat[1]), 1);
        tick();
        check("win_flag", int'(bus.o_win), 1);
        check("win_score", int'(bus.o_score), 10);
        check("win_leds", int'(bus.o_led), 15);

        // Wrong channel in round 0.
        start_combo();
        wait_for(MD_WAIT, 100);
        w = (int'(m_pat[0]) + 1 + int'($urandom_range(0, 2))) % 4;
        press_release(w, 1);
        check("wrong_lose", int'(bus.o_lose), 1);
        check("wrong_score", int'(bus.o_score), 15);
        check("wrong_leds", int'(bus.o_led), 0);

        // Two channels released together.
        start_combo();
        wait_for(MD_WAIT, 100);
        sw = 4'b0110;
        tick();
        sw = 4'b0000;
        tick();
        check("double_release_lose", int'(bus.o_lose), 1);

        // Idle player.
        start_combo();
        wait_for(MD_WAIT, 100);
        repeat (100) tick();
`ifdef PATTERN_GAME_TIMEOUT_EN
        check("idle_timeout_lose", int'(bus.o_lose), 1);
`else
        check("idle_no_lose", int'(bus.o_lose), 0);
        check("idle_score", int'(bus.o_score), 0);
        sw = 4'b0110;
        tick();
        sw = 4'b0000;
        tick();
`endif

        // Asynchronous reset while a pattern element is lit.
        start_combo();
        tick();
        tick();
        check("show_lit_before_reset", int'(bus.o_led != 4'h0), 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_led", int'(bus.o_led), 0);
        check("async_reset_score", int'(bus.o_score), 0);
        check("async_reset_win", int'(bus.o_win), 0);
        check("async_reset_lose", int'(bus.o_lose), 0);
        sw = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        for (int g = 0; g < 16; g++) play_game(int'($urandom_range(0, 25)));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
